// File: rtl/cmplx_mult_sched.sv
// Complex multiply sequencer: one (ar + j*ai)*(wr + j*wi) per transaction,
// time-multiplexed over a single shared external signed fixed-point multiplier.
module cmplx_mult_sched #(
    parameter int WORD_SIZE = 37
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] a_re,
    input  logic [WORD_SIZE-1:0] a_im,
    input  logic [WORD_SIZE-1:0] w_re,
    input  logic [WORD_SIZE-1:0] w_im,
    output logic [WORD_SIZE-1:0] mult_a,
    output logic [WORD_SIZE-1:0] mult_b,
    input  logic [WORD_SIZE-1:0] mult_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] p_re,
    output logic [WORD_SIZE-1:0] p_im,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends combinationally on ready on either side.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_RR = 3'd1,
        MUL_II = 3'd2,
        MUL_RI = 3'd3,
        MUL_IR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                 state_q,  state_d;
    logic [WORD_SIZE-1:0]   ar_q,     ar_d;
    logic [WORD_SIZE-1:0]   ai_q,     ai_d;
    logic [WORD_SIZE-1:0]   wr_q,     wr_d;
    logic [WORD_SIZE-1:0]   wi_q,     wi_d;
    logic [WORD_SIZE-1:0]   acc_re_q, acc_re_d;
    logic [WORD_SIZE-1:0]   acc_im_q, acc_im_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ar_q     <= '0;
            ai_q     <= '0;
            wr_q     <= '0;
            wi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            wr_q     <= wr_d;
            wi_q     <= wi_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        ai_d     = ai_q;
        wr_d     = wr_q;
        wi_d     = wi_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        mult_a   = '0;
        mult_b   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ar_d    = a_re;
                    ai_d    = a_im;
                    wr_d    = w_re;
                    wi_d    = w_im;
                    state_d = MUL_RR;
                end
            end
            MUL_RR: begin
                mult_a   = ar_q;
                mult_b   = wr_q;
                acc_re_d = mult_c;
                state_d  = MUL_II;
            end
            MUL_II: begin
                mult_a   = ai_q;
                mult_b   = wi_q;
                acc_re_d = acc_re_q - mult_c;
                state_d  = MUL_RI;
            end
            MUL_RI: begin
                mult_a   = ar_q;
                mult_b   = wi_q;
                acc_im_d = mult_c;
                state_d  = MUL_IR;
            end
            MUL_IR: begin
                mult_a   = ai_q;
                mult_b   = wr_q;
                acc_im_d = acc_im_q + mult_c;
                state_d  = DONE;
            end
            DONE: begin
                // No bypass to a new transaction: IDLE must be visited first.
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p_re      = acc_re_q;
    assign p_im      = acc_im_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cmplx_mult_sched.sv
// Directed bench for cmplx_mult_sched with a behavioural model of the shared
// 37-bit signed fixed-point multiplier (1.0 = 0x40000) on the mult ports.
module tb_cmplx_mult_sched;
    localparam int W = 37;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_re, a_im, w_re, w_im;
    logic [W-1:0] mult_a, mult_b, mult_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p_re, p_im;
    logic         busy;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmplx_mult_sched #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
        .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_re(p_re), .p_im(p_im), .busy(busy), .dbg_state(dbg_state)
    );

    // double_sign_mult model: full signed product, 18 fraction bits dropped.
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, f;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        f  = sa * sb;
        return f[W+17:18];
    endfunction

    assign mult_c = fx_mul(mult_a, mult_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [W-1:0] ar, input logic [W-1:0] ai,
                             input logic [W-1:0] wr, input logic [W-1:0] wi);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", W'(in_ready), W'(1));
        a_re = ar; a_im = ai; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Runs the four multiply cycles after acceptance and checks operand order.
    task automatic mul_phase(input string tag, input logic [W-1:0] ar, input logic [W-1:0] ai,
                             input logic [W-1:0] wr, input logic [W-1:0] wi);
        logic [W-1:0] ea[4];
        logic [W-1:0] eb[4];
        ea[0] = ar; ea[1] = ai; ea[2] = ar; ea[3] = ai;
        eb[0] = wr; eb[1] = wi; eb[2] = wi; eb[3] = wr;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy_out_valid"}, W'({busy, out_valid}), W'(2'b10));
            check({tag, "_mult_a"}, mult_a, ea[i]);
            check({tag, "_mult_b"}, mult_b, eb[i]);
            tick();
        end
    endtask

    task automatic run_txn(input string tag, input logic [W-1:0] ar, input logic [W-1:0] ai,
                           input logic [W-1:0] wr, input logic [W-1:0] wi,
                           input logic [W-1:0] exp_re, input logic [W-1:0] exp_im);
        start_txn(ar, ai, wr, wi);
        mul_phase(tag, ar, ai, wr, wi);
        check({tag, "_out_valid"}, W'(out_valid), W'(1));
        check({tag, "_p_re"}, p_re, exp_re);
        check({tag, "_p_im"}, p_im, exp_im);
        check({tag, "_mult_idle"}, mult_a | mult_b, '0);
        tick();
        check({tag, "_release"}, W'({in_ready, out_valid, busy}), W'(3'b100));
    endtask

    initial begin
        logic [63:0]  r;
        logic [W-1:0] ar, ai, wr, wi, er, ei, hold_re, hold_im;

        // Reset held two cycles while in_valid is asserted.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a_re = 37'h12345; a_im = 37'h54321; w_re = 37'h0ABCD; w_im = 37'h1DCBA;
        tick();
        tick();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_p_re", p_re, '0);
        check("rst_p_im", p_im, '0);
        check("rst_mult_a", mult_a, '0);
        check("rst_mult_b", mult_b, '0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // 1 * j = j
        run_txn("basic", 37'h40000, 37'h0, 37'h0, 37'h40000, 37'h0, 37'h40000);

        // (2 + 3j)(4 - j) = 11 + 10j
        run_txn("signed", 37'h80000, 37'hC0000, 37'h100000, 37'h1FFFFC0000,
                37'h2C0000, 37'h280000);

        // Backpressure: (3 - 2j)(0.5 + 1.5j) = 4.5 + 3.5j held for 7 cycles
        out_ready = 1'b0;
        start_txn(37'hC0000, 37'h1FFFF80000, 37'h20000, 37'h60000);
        mul_phase("bp", 37'hC0000, 37'h1FFFF80000, 37'h20000, 37'h60000);
        check("bp_out_valid", W'(out_valid), W'(1));
        check("bp_p_re", p_re, 37'h120000);
        check("bp_p_im", p_im, 37'hE0000);
        hold_re = 37'h120000;
        hold_im = 37'hE0000;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            r = {$urandom(), $urandom()};
            a_re = r[36:0]; a_im = r[63:27];
            w_re = W'($urandom()); w_im = W'($urandom());
            tick();
            check("bp_hold_p_re", p_re, hold_re);
            check("bp_hold_p_im", p_im, hold_im);
            check("bp_hold_ready_valid", W'({in_ready, out_valid}), W'(2'b01));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", W'({in_ready, out_valid, busy}), W'(3'b100));

        // Reset during MUL_II discards the transaction.
        start_txn(37'h40000, 37'h80000, 37'hC0000, 37'h100000);
        tick();
        check("midrst_in_mul_ii", mult_a, 37'h80000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_idle", W'({in_ready, out_valid, busy}), W'(3'b100));
        check("midrst_p_re", p_re, '0);
        check("midrst_p_im", p_im, '0);
        check("midrst_mult", mult_a | mult_b, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_output", W'(out_valid), W'(0));
        end
        // (1 + j)(1 + j) = 2j
        run_txn("post_rst", 37'h40000, 37'h40000, 37'h40000, 37'h40000, 37'h0, 37'h80000);

        // Streaming random transactions against a complex reference with wrap.
        for (int t = 0; t < 20; t++) begin
            r = {$urandom(), $urandom()};
            ar = r[36:0];
            r = {$urandom(), $urandom()};
            ai = r[36:0];
            r = {$urandom(), $urandom()};
            wr = r[36:0];
            r = {$urandom(), $urandom()};
            wi = r[36:0];
            er = fx_mul(ar, wr) - fx_mul(ai, wi);
            ei = fx_mul(ar, wi) + fx_mul(ai, wr);
            run_txn($sformatf("stream%0d", t), ar, ai, wr, wi, er, ei);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
